// File: rtl/mux2_arbiter_pkg.sv
// Shared types for the two-requester round-robin arbiter.
// The state encoding keeps 2'd3 unused; the FSM recovers it to IDLE.
package mux2_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mux_2.sv
// Single-bit 2:1 select cell of the shared datapath; sel=0 picks a, sel=1 picks b.
module mux_2 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin arbiter sharing one DATA_W-bit 2:1 path between requesters A and B,
// holding the grant for a transfer and pre-empting a holder after MAX_HOLD cycles.
module mux2_arbiter
  import mux2_arbiter_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              last_a,
  input  logic              last_b,
  input  logic              valid_a,
  input  logic              valid_b,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              sel,
  output logic              busy,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid
);

  localparam int              CNT_W   = $clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  arb_state_t       state_r;
  arb_state_t       next_state_s;
  logic             prio_r;
  logic             next_prio_s;
  logic [CNT_W-1:0] hold_cnt_r;
  logic             end_a_s;
  logic             end_b_s;

  // Next-state and priority decision from the current state and requests
  always_comb begin
    end_a_s      = !req_a || last_a || ((hold_cnt_r == CNT_MAX) && req_b);
    end_b_s      = !req_b || last_b || ((hold_cnt_r == CNT_MAX) && req_a);
    next_state_s = state_r;
    next_prio_s  = prio_r;
    case (state_r)
      IDLE: begin
        if (req_a && (!req_b || !prio_r)) begin
          next_state_s = GNT_A;
        end else if (req_b) begin
          next_state_s = GNT_B;
        end else begin
          next_state_s = IDLE;
        end
      end
      GNT_A: begin
        if (end_a_s) begin
          next_prio_s  = 1'b1;
          next_state_s = req_b ? GNT_B : IDLE;
        end else begin
          next_state_s = GNT_A;
        end
      end
      GNT_B: begin
        if (end_b_s) begin
          next_prio_s  = 1'b0;
          next_state_s = req_a ? GNT_A : IDLE;
        end else begin
          next_state_s = GNT_B;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // FSM state, priority, hold counter and registered grant outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r    <= IDLE;
      prio_r     <= 1'b0;
      hold_cnt_r <= '0;
      gnt_a      <= 1'b0;
      gnt_b      <= 1'b0;
      sel        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_r <= next_state_s;
      prio_r  <= next_prio_s;
      gnt_a   <= (next_state_s == GNT_A);
      gnt_b   <= (next_state_s == GNT_B);
      sel     <= (next_state_s == GNT_B);
      busy    <= (next_state_s != IDLE);
      // The counter restarts on every grant entry, including a direct handover.
      if ((next_state_s == IDLE) || (next_state_s != state_r)) begin
        hold_cnt_r <= '0;
      end else if (hold_cnt_r != CNT_MAX) begin
        hold_cnt_r <= hold_cnt_r + CNT_W'(1);
      end else begin
        hold_cnt_r <= hold_cnt_r;
      end
    end
  end

  for (genvar i = 0; i < DATA_W; i++) begin : g_mux
    mux_2 u_mux (
      .a  (data_a[i]),
      .b  (data_b[i]),
      .sel(sel),
      .y  (out_data[i])
    );
  end

  assign out_valid = (gnt_a & valid_a) | (gnt_b & valid_b);

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed plus randomized bench for mux2_arbiter, checked against an
// owner/priority/beat-count reference model.
module tb_mux2_arbiter;

  localparam int DATA_W   = 8;
  localparam int MAX_HOLD = 16;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic              req_a, req_b, last_a, last_b, valid_a, valid_b;
  logic [DATA_W-1:0] data_a, data_b;
  logic              gnt_a, gnt_b, sel, busy, out_valid;
  logic [DATA_W-1:0] out_data;

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the path, who is preferred, grant cycles so far
  int m_owner = 0;   // 0 none, 1 A, 2 B
  bit m_prio  = 1'b0;
  int m_held  = 0;

  always #5 sys_clk = ~sys_clk;

  mux2_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .req_a    (req_a),
    .req_b    (req_b),
    .last_a   (last_a),
    .last_b   (last_b),
    .valid_a  (valid_a),
    .valid_b  (valid_b),
    .data_a   (data_a),
    .data_b   (data_b),
    .gnt_a    (gnt_a),
    .gnt_b    (gnt_b),
    .sel      (sel),
    .busy     (busy),
    .out_data (out_data),
    .out_valid(out_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    bit ends;
    if (!sys_rst_n) begin
      m_owner = 0; m_prio = 1'b0; m_held = 0;
    end else if (m_owner == 0) begin
      m_held = 0;
      if (req_a && (!req_b || !m_prio)) m_owner = 1;
      else if (req_b)                   m_owner = 2;
    end else if (m_owner == 1) begin
      ends = !req_a || last_a || (m_held >= MAX_HOLD - 1 && req_b);
      if (ends) begin m_prio = 1'b1; m_owner = req_b ? 2 : 0; m_held = 0; end
      else m_held++;
    end else begin
      ends = !req_b || last_b || (m_held >= MAX_HOLD - 1 && req_a);
      if (ends) begin m_prio = 1'b0; m_owner = req_a ? 1 : 0; m_held = 0; end
      else m_held++;
    end
  endtask

  task automatic check_comb();
    logic              ev;
    logic [DATA_W-1:0] ed;
    ev = (m_owner == 1 && valid_a) || (m_owner == 2 && valid_b);
    ed = (m_owner == 2) ? data_b : data_a;
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("out_data",  32'(out_data),  32'(ed));
  endtask

  // One clock: check combinational outputs, clock, update model, check grants.
  task automatic step();
    #1;
    check_comb();
    @(posedge sys_clk);
    model_update();
    #1;
    chk("gnt_a", 32'(gnt_a), 32'(m_owner == 1));
    chk("gnt_b", 32'(gnt_b), 32'(m_owner == 2));
    chk("sel",   32'(sel),   32'(m_owner == 2));
    chk("busy",  32'(busy),  32'(m_owner != 0));
  endtask

  task automatic quiet();
    req_a = 1'b0; req_b = 1'b0; last_a = 1'b0; last_b = 1'b0;
    valid_a = 1'b0; valid_b = 1'b0;
  endtask

  initial begin
    int cnt;
    bit seen_b;
    sys_rst_n = 1'b0;
    quiet();
    data_a = 8'h00; data_b = 8'h5A;
    #2;
    chk("rst_gnt_a", 32'(gnt_a), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_data",  32'(out_data), 32'(data_a));
    step(); step();
    sys_rst_n = 1'b1;
    step();

    // Single requester, four beats 0x11..0x14, last on the fourth
    req_a = 1'b1; valid_a = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      data_a  = 8'(8'h11 + i);
      valid_a = 1'b1;
      last_a  = (i == 3);
      #1;
      chk("single_data",  32'(out_data),  32'(8'h11 + i));
      chk("single_valid", 32'(out_valid), 32'd1);
      step();
    end
    quiet();
    chk("single_drop", 32'(gnt_a), 32'd0);
    step(); step();

    // Alternation with last every third granted beat
    req_a = 1'b1; req_b = 1'b1; valid_a = 1'b1; valid_b = 1'b1;
    for (int i = 0; i < 14; i++) begin
      last_a = (m_owner == 1 && m_held == 2);
      last_b = (m_owner == 2 && m_held == 2);
      data_a = 8'($urandom); data_b = 8'($urandom);
      step();
    end
    quiet();
    step(); step();

    // Pre-emption: req_b arrives at cycle 5, A never signals last
    req_a = 1'b1;
    cnt = 0; seen_b = 1'b0;
    for (int i = 0; i < 40 && !seen_b; i++) begin
      if (i == 5) req_b = 1'b1;
      step();
      if (gnt_a) cnt++;
      if (gnt_b) seen_b = 1'b1;
    end
    chk("preempt_seen_b", 32'(seen_b), 32'd1);
    chk("preempt_cycles", 32'(cnt), 32'(MAX_HOLD));
    quiet();
    step(); step();

    // No pre-emption without a competitor; then isolation from B
    req_a = 1'b1;
    for (int i = 0; i < 40; i++) begin
      valid_a = i[0]; data_a = 8'($urandom);
      valid_b = ~i[0] | i[1]; data_b = 8'hFF; last_b = i[2];
      step();
      #1;
      chk("iso_data",  32'(out_data),  32'(data_a));
      chk("iso_valid", 32'(out_valid), 32'(valid_a));
    end
    quiet();
    step(); step();

    // Reset mid-GNT_B, then restart with prio=0
    req_b = 1'b1; valid_b = 1'b1;
    step(); step();
    chk("pre_rst_gnt_b", 32'(gnt_b), 32'd1);
    sys_rst_n = 1'b0;
    #1;
    model_update();
    chk("rst_mid_gnt_b", 32'(gnt_b),     32'd0);
    chk("rst_mid_busy",  32'(busy),      32'd0);
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    step();
    sys_rst_n = 1'b1;
    req_a = 1'b1; req_b = 1'b1;
    step();
    chk("post_rst_gnt_a", 32'(gnt_a), 32'd1);
    quiet();
    step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      req_a   = ($urandom_range(0, 3) != 0);
      req_b   = ($urandom_range(0, 3) != 0);
      last_a  = ($urandom_range(0, 9) == 0);
      last_b  = ($urandom_range(0, 9) == 0);
      valid_a = 1'($urandom);
      valid_b = 1'($urandom);
      data_a  = 8'($urandom);
      data_b  = 8'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
